div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; all requirements are stated for WIDTH=32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clear  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a division; sampled on rising clk edges.
REQ-005 RA  input  32  dividend, two's-complement signed.
REQ-006 RB  input  32  divisor, two's-complement signed.
REQ-007 LO  output  32  quotient, signed, registered.
REQ-008 HI  output  32  remainder, signed, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  single-cycle pulse marking LO/HI valid.
REQ-011 div_by_zero  output  1  registered flag: last accepted operation had RB==0.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN, FIX and DONE.
REQ-013 In IDLE, start=1 at an edge SHALL capture RA/RB internally and set busy=1; later RA/RB changes SHALL NOT affect the result.
REQ-014 At capture, when RB!=0, the block SHALL store |RA| and |RB| as 32-bit unsigned magnitudes (|0x80000000| = 2^31), clear the 33-bit partial remainder and counter, and enter RUN.
REQ-015 RUN SHALL perform one restoring step per cycle: shift remainder:quotient left 1, compute trial = remainder - |RB| through the two-operand 33-bit add path (remainder + ~|RB| + 1), keep trial and set quotient LSB=1 if trial>=0, else restore and set LSB=0.
REQ-016 RUN SHALL last exactly 32 cycles (counter 0..31), then enter FIX.
REQ-017 FIX SHALL negate the quotient if RA[31]^RB[31]=1, negate the remainder if RA[31]=1, load LO/HI, and enter DONE.
REQ-018 DONE SHALL hold done=1 for exactly one cycle, drop busy and done together on the next edge, and return to IDLE.
REQ-019 Latency: with start sampled at edge E0, done SHALL be high for the cycle after edge E0+34 and busy SHALL be high from E0 through E0+35.
REQ-020 When RB==0 at capture, the block SHALL enter DONE directly (done high after E0+1) with LO=32'hFFFFFFFF, HI=RA and div_by_zero=1.
REQ-021 div_by_zero SHALL clear to 0 at capture of any operation with RB!=0.
REQ-022 RA=0x80000000 with RB=0xFFFFFFFF SHALL produce LO=0x80000000, HI=0, div_by_zero=0 (wrap, no trap).
REQ-023 A zero remainder SHALL be reported as 0 regardless of sign.
REQ-024 start while busy=1, including during DONE, SHALL be ignored, with no effect on the current operation.
REQ-025 LO/HI SHALL change only in FIX or on the zero-divisor path, and SHALL hold their values through IDLE until the next result.
REQ-026 start asserted on the edge after done (back in IDLE) SHALL be accepted normally.

Reset
REQ-027 clear=1 SHALL immediately, without waiting for clk, force state=IDLE, LO=0, HI=0, busy=0, done=0, div_by_zero=0, and zero the counter and the internal registers.
REQ-028 clear asserted mid-operation SHALL abort it with no done pulse; the first start after clear deasserts SHALL begin a fresh operation.
REQ-029 While clear=1, start SHALL be ignored.

Verification
REQ-030 RA=7, RB=2, start for 1 cycle -> done pulses once 34 cycles later; LO=3, HI=1, div_by_zero=0.
REQ-031 RA=-7 (0xFFFFFFF9), RB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; RA=7, RB=-2 -> LO=0xFFFFFFFD, HI=1.
REQ-032 RA=0x12345678, RB=0 -> done after 1 cycle; LO=0xFFFFFFFF, HI=0x12345678, div_by_zero=1; a following 100/7 -> LO=14, HI=2, div_by_zero=0.
REQ-033 RA=0x80000000, RB=0xFFFFFFFF -> LO=0x80000000, HI=0; RA=0x80000000, RB=1 -> LO=0x80000000, HI=0.
REQ-034 Start 1000/3; at cycle 10 pulse start with RA=5, RB=5 -> ignored, result LO=333, HI=1; then start 1000/3 again and assert clear asynchronously at cycle 20 -> all outputs 0 at once, no done pulse.
REQ-035 Back-to-back: 9/4, then start on the edge after done with 15/5 -> results LO=2/HI=1, then LO=3/HI=0, each with exactly one done pulse.

Source files
------------

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential signed restoring divider (quotient LO, remainder HI)
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] RA,
    input  logic [WIDTH-1:0] RB,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] HI,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Magnitudes and sign bookkeeping captured at start.
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;

    // One restoring step: working value is WIDTH+1 bits wide.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // Absolute values of the operands; the most negative value maps to 2^(WIDTH-1).
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // Operand magnitudes for capture.
    always_comb begin
        abs_a = RA[WIDTH-1] ? (~RA + WIDTH'(1)) : RA;
        abs_b = RB[WIDTH-1] ? (~RB + WIDTH'(1)) : RB;
    end

    // Shift remainder:quotient left, subtract divisor via add of its complement, restore on borrow.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh + {1'b1, ~dvs} + (WIDTH+1)'(1);
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = rem_sh[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: DONE spends one cycle arming done, a second with done high, then returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (RB == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; LO/HI only move in FIX or on the zero-divisor capture.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            LO          <= '0;
            HI          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            dvs         <= '0;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (RB == '0) begin
                            LO          <= '1;
                            HI          <= RA;
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                            quo         <= abs_a;
                            dvs         <= abs_b;
                            rem         <= '0;
                            cnt         <= '0;
                            neg_q       <= RA[WIDTH-1] ^ RB[WIDTH-1];
                            neg_r       <= RA[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    LO <= neg_q ? (~quo + WIDTH'(1)) : quo;
                    HI <= neg_r ? (~rem + WIDTH'(1)) : rem;
                end
                DONE: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq
module tb_div_seq;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] RA;
    logic [31:0] RB;
    logic [31:0] LO;
    logic [31:0] HI;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .RA         (RA),
        .RB         (RB),
        .LO         (LO),
        .HI         (HI),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          e0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done-high sample must match the oldest expected result.
    always @(negedge clk) begin
        if (clear === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("LO", LO, e.lo);
                chk("HI", HI, e.hi);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                chk("done_latency", 32'(cyc - e.e0), 32'(e.lat));
                chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi,
                         input logic dz, input int lat, input int inj);
        exp_t e;
        int   waited;
        @(negedge clk);
        RA = a;
        RB = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.lo = lo; e.hi = hi; e.dz = dz; e.e0 = cyc; e.lat = lat;
        sb.push_back(e);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        RA = $urandom;
        RB = $urandom;
        if (inj > 0) begin
            repeat (inj - 1) @(negedge clk);
            RA = 32'd5;
            RB = 32'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waited = 0;
        while (done !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 expected=1 for %h/%h", a, b);
        end
        @(negedge clk);
        chk("busy_drop", {31'd0, busy}, 32'd0);
        chk("done_width", {31'd0, done}, 32'd0);
        chk("LO_idle", LO, lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        clear = 1'b1;
        start = 1'b0;
        RA = 32'd0;
        RB = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_LO", LO, 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_dz", {31'd0, div_by_zero}, 32'd0);
        clear = 1'b0;
        repeat (2) @(negedge clk);

        do_op(32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 34, 0);
        do_op(32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, 0);
        do_op(32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34, 0);
        do_op(32'hFFFFFFFA, 32'd3,        32'hFFFFFFFE, 32'd0,        1'b0, 34, 0);
        do_op(32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1, 1,  0);
        do_op(32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34, 0);
        do_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34, 0);
        do_op(32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 34, 0);
        do_op(32'd1000,     32'd3,        32'd333,      32'd1,        1'b0, 34, 10);

        // Results hold while idle.
        repeat (5) @(negedge clk);
        chk("LO_hold", LO, 32'd333);
        chk("HI_hold", HI, 32'd1);

        // Abort an operation with an asynchronous clear; no done may follow.
        @(negedge clk);
        RA = 32'd1000;
        RB = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        @(posedge clk);
        #3;
        clear = 1'b1;
        #1;
        chk("clear_LO", LO, 32'd0);
        chk("clear_HI", HI, 32'd0);
        chk("clear_busy", {31'd0, busy}, 32'd0);
        chk("clear_done", {31'd0, done}, 32'd0);
        chk("clear_dz", {31'd0, div_by_zero}, 32'd0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("start_during_clear", {31'd0, busy}, 32'd0);
        start = 1'b0;
        clear = 1'b0;
        repeat (40) @(negedge clk);
        chk("idle_after_abort", {31'd0, busy}, 32'd0);

        // Fresh operation after clear, then back-to-back pair.
        do_op(32'd7,  32'd2, 32'd3, 32'd1, 1'b0, 34, 0);
        do_op(32'd9,  32'd4, 32'd2, 32'd1, 1'b0, 34, 0);
        do_op(32'd15, 32'd5, 32'd3, 32'd0, 1'b0, 34, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
